race_reaction_timer: RTL and testbench

Driver-side judge for the drag-race start tree. It watches the RED/YELLOW/GREEN lights produced by the race light sequencer and the driver's GO input. It measures reaction time from GREEN to GO in prescaled ticks and flags false starts and timeouts. It sits on the consuming end of the light interface and shares CLK/RESET with the sequencer.

---
 rtl/race_pkg.sv | 19 +
 rtl/race_tick_gen.sv | 42 ++++
 rtl/race_reaction_timer.sv | 146 ++++++++++++++
 tb/tb_race_reaction_timer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared types and default constants for the race start tree
// Contents:
//   race_state_t   judge FSM states (IDLE, ARMED, TIMING, DONE, FOUL_ST)
//   RACE_CNT_W     default reaction counter width
//   RACE_TICK_DIV  default clock cycles per counted tick
package race_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        TIMING  = 3'd2,
        DONE    = 3'd3,
        FOUL_ST = 3'd4
    } race_state_t;

    localparam int RACE_CNT_W    = 16;
    localparam int RACE_TICK_DIV = 1;

endpackage

// File: rtl/race_tick_gen.sv
// rtl/race_tick_gen.sv - TICK_DIV prescaler producing a one-cycle counting tick
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   clear  in   synchronous clear of the prescaler phase
//   en     in   advance the prescaler this cycle
//   tick   out  high for one cycle when the prescaler wraps (combinational from state)
module race_tick_gen #(
    parameter int TICK_DIV = race_pkg::RACE_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    generate
        if (TICK_DIV <= 1) begin : g_bypass
            // Every enabled cycle is a tick; no phase state is needed.
            logic unused_bypass;
            assign unused_bypass = clk ^ reset ^ clear;
            assign tick = en;
        end else begin : g_div
            localparam int PW = $clog2(TICK_DIV);
            localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

            logic [PW-1:0] phase;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    phase <= '0;
                end else if (en) begin
                    phase <= (phase == LAST) ? '0 : phase + 1'b1;
                end
            end

            assign tick = en && (phase == LAST);
        end
    endgenerate

endmodule

// File: rtl/race_reaction_timer.sv
// rtl/race_reaction_timer.sv - driver-side judge: reaction time, false start and timeout
// Optional feature macro: RACE_TIMER_BEST_EN (adds best_time register and port).
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   red         in   sequencer red light
//   yellow      in   sequencer yellow light (informational only)
//   green       in   sequencer green light
//   go          in   driver launch input, already synchronous to clk
//   react_time  out  latched reaction time in ticks
//   valid       out  react_time holds a legal result
//   foul        out  false start detected
//   timeout     out  counter saturated without go
//   busy        out  high while ARMED or TIMING
//   best_time   out  best valid reaction time (RACE_TIMER_BEST_EN only)
module race_reaction_timer
    import race_pkg::*;
#(
    parameter int CNT_W    = RACE_CNT_W,
    parameter int TICK_DIV = RACE_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             go,
    output logic [CNT_W-1:0] react_time,
    output logic             valid,
    output logic             foul,
    output logic             timeout,
    output logic             busy
`ifdef RACE_TIMER_BEST_EN
    ,
    output logic [CNT_W-1:0] best_time
`endif
);

    race_state_t      state;
    logic             go_q;
    logic             red_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             go_edge;
    logic             red_edge;
    logic             sat;
    logic             tick;
    logic             unused_yellow;

    assign unused_yellow = yellow;

    // Edge history resets high so inputs held high through reset are not edges.
    assign go_edge  = go  && !go_q;
    assign red_edge = red && !red_q;

    // Counter value including this cycle's tick; saturation is judged on it.
    assign cnt_next = cnt + {{(CNT_W-1){1'b0}}, tick};
    assign sat      = (cnt_next == '1);

    // Prescaler is held at phase zero while armed so timing starts cleanly.
    race_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state == ARMED),
        .en    (state == TIMING),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            go_q       <= 1'b1;
            red_q      <= 1'b1;
            cnt        <= '0;
            react_time <= '0;
            valid      <= 1'b0;
            foul       <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            go_q  <= go;
            red_q <= red;
            case (state)
                IDLE: begin
                    if (red) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    // A launch before or together with green is a false start.
                    if (go_edge) begin
                        state <= FOUL_ST;
                        foul  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (green) begin
                        state <= TIMING;
                        cnt   <= '0;
                    end
                end
                TIMING: begin
                    cnt <= cnt_next;
                    // go takes precedence over saturation on the same edge.
                    if (go_edge) begin
                        state      <= DONE;
                        react_time <= cnt_next;
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                    end else if (sat) begin
                        state      <= DONE;
                        react_time <= '1;
                        timeout    <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                DONE, FOUL_ST: begin
                    // react_time is intentionally kept across re-arming.
                    if (red_edge) begin
                        state   <= ARMED;
                        valid   <= 1'b0;
                        foul    <= 1'b0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RACE_TIMER_BEST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            best_time <= '1;
        end else if (state == TIMING && go_edge && cnt_next < best_time) begin
            best_time <= cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_race_reaction_timer.sv
// tb/tb_race_reaction_timer.sv - directed self-checking bench for race_reaction_timer
module tb_race_reaction_timer;
    import race_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic red = 1'b0;
    logic yellow = 1'b0;
    logic green = 1'b0;
    logic go = 1'b0;

    logic [7:0] react8, react3;
    logic [3:0] react4;
    logic valid8, foul8, timeout8, busy8;
    logic valid4, foul4, timeout4, busy4;
    logic valid3, foul3, timeout3, busy3;
`ifdef RACE_TIMER_BEST_EN
    logic [7:0] best8, best3;
    logic [3:0] best4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    race_reaction_timer #(.CNT_W(8), .TICK_DIV(1)) dut8 (
        .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .go(go),
        .react_time(react8), .valid(valid8), .foul(foul8), .timeout(timeout8), .busy(busy8)
`ifdef RACE_TIMER_BEST_EN
        , .best_time(best8)
`endif
    );

    race_reaction_timer #(.CNT_W(4), .TICK_DIV(1)) dut4 (
        .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .go(go),
        .react_time(react4), .valid(valid4), .foul(foul4), .timeout(timeout4), .busy(busy4)
`ifdef RACE_TIMER_BEST_EN
        , .best_time(best4)
`endif
    );

    race_reaction_timer #(.CNT_W(8), .TICK_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .go(go),
        .react_time(react3), .valid(valid3), .foul(foul3), .timeout(timeout3), .busy(busy3)
`ifdef RACE_TIMER_BEST_EN
        , .best_time(best3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Starts from DONE/FOUL_ST/IDLE with red low; one red pulse then either a
    // clean race with go at edge c, or a go pulse while armed.
    task automatic race(input int c, input bit is_foul, input int prev_react, input int exp_best);
        red = 1'b1;
        tick();
        check("race_rearm_valid", 32'(valid8), 0);
        check("race_rearm_busy", 32'(busy8), 1);
        check("race_rearm_keep", 32'(react8), prev_react);
        red = 1'b0;
        tick();
        if (is_foul) begin
            go = 1'b1;
            tick();
            check("race_foul", 32'(foul8), 1);
            check("race_foul_keep", 32'(react8), prev_react);
            go = 1'b0;
            tick();
        end else begin
            green = 1'b1;
            tick();
            repeat (c - 1) tick();
            go = 1'b1;
            tick();
            check("race_react", 32'(react8), c);
            check("race_valid", 32'(valid8), 1);
            go = 1'b0;
            green = 1'b0;
            tick();
        end
`ifdef RACE_TIMER_BEST_EN
        check("race_best", 32'(best8), exp_best);
`else
        if (exp_best < 0) check("race_best_arg", 32'(exp_best), 0);
`endif
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_react", 32'(react8), 0);
        check("rst_valid", 32'(valid8), 0);
        check("rst_foul", 32'(foul8), 0);
        check("rst_timeout", 32'(timeout8), 0);
        check("rst_busy", 32'(busy8), 0);
`ifdef RACE_TIMER_BEST_EN
        check("rst_best", 32'(best8), 255);
`endif

        // Normal race, go at edge 5
        red = 1'b1;
        tick();
        check("norm_busy_armed", 32'(busy8), 1);
        red = 1'b0;
        yellow = 1'b1;
        tick();
        yellow = 1'b0;
        green = 1'b1;
        tick();
        check("norm_busy_timing", 32'(busy8), 1);
        repeat (4) tick();
        go = 1'b1;
        tick();
        check("norm_react", 32'(react8), 5);
        check("norm_valid", 32'(valid8), 1);
        check("norm_foul", 32'(foul8), 0);
        check("norm_busy", 32'(busy8), 0);
        check("norm_timeout", 32'(timeout8), 0);
        check("norm_div3_react", 32'(react3), 1);
        check("norm_w4_react", 32'(react4), 5);
        go = 1'b0;
        green = 1'b0;

        // False start during yellow
        do_reset();
        red = 1'b1;
        tick();
        red = 1'b0;
        yellow = 1'b1;
        tick();
        go = 1'b1;
        tick();
        check("fs_foul", 32'(foul8), 1);
        check("fs_valid", 32'(valid8), 0);
        check("fs_busy", 32'(busy8), 0);
        go = 1'b0;
        tick();
        yellow = 1'b0;
        green = 1'b1;
        tick();
        tick();
        check("fs_green_react", 32'(react8), 0);
        check("fs_green_foul", 32'(foul8), 1);
        check("fs_green_busy", 32'(busy8), 0);
        green = 1'b0;

        // Green and go edge on the same clock
        do_reset();
        red = 1'b1;
        tick();
        red = 1'b0;
        tick();
        green = 1'b1;
        go = 1'b1;
        tick();
        check("sim_foul", 32'(foul8), 1);
        check("sim_state", 32'(dut8.state), 32'(FOUL_ST));
        check("sim_valid", 32'(valid8), 0);
        go = 1'b0;
        green = 1'b0;

        // Timeout with 4-bit counter
        do_reset();
        red = 1'b1;
        tick();
        red = 1'b0;
        tick();
        green = 1'b1;
        tick();
        repeat (14) tick();
        check("to_pre_busy", 32'(busy4), 1);
        check("to_pre_timeout", 32'(timeout4), 0);
        tick();
        check("to_timeout", 32'(timeout4), 1);
        check("to_valid", 32'(valid4), 0);
        check("to_react", 32'(react4), 15);
        check("to_busy", 32'(busy4), 0);
        green = 1'b0;

        // Go on the saturating edge wins
        do_reset();
        red = 1'b1;
        tick();
        red = 1'b0;
        tick();
        green = 1'b1;
        tick();
        repeat (14) tick();
        go = 1'b1;
        tick();
        check("tog_valid", 32'(valid4), 1);
        check("tog_timeout", 32'(timeout4), 0);
        check("tog_react", 32'(react4), 15);
        check("tog_w8_react", 32'(react8), 15);
        go = 1'b0;
        green = 1'b0;

        // Reset mid-TIMING with go held high
        do_reset();
        go = 1'b1;
        tick();
        red = 1'b1;
        tick();
        red = 1'b0;
        green = 1'b1;
        tick();
        tick();
        tick();
        check("hold_busy", 32'(busy8), 1);
        check("hold_foul", 32'(foul8), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_react", 32'(react8), 0);
        check("mid_rst_valid", 32'(valid8), 0);
        check("mid_rst_foul", 32'(foul8), 0);
        check("mid_rst_timeout", 32'(timeout8), 0);
        check("mid_rst_busy", 32'(busy8), 0);
        green = 1'b0;
        red = 1'b1;
        tick();
        check("rearm_busy", 32'(busy8), 1);
        red = 1'b0;
        tick();
        tick();
        check("rearm_nofoul", 32'(foul8), 0);
        go = 1'b0;
        tick();
        check("rearm_nofoul_low", 32'(foul8), 0);
        go = 1'b1;
        tick();
        check("rearm_foul", 32'(foul8), 1);
        check("rearm_foul_busy", 32'(busy8), 0);
        go = 1'b0;

        // Prescaled race: go at edge 10 with TICK_DIV=3
        do_reset();
        red = 1'b1;
        tick();
        red = 1'b0;
        tick();
        green = 1'b1;
        tick();
        repeat (9) tick();
        go = 1'b1;
        tick();
        check("div3_react", 32'(react3), 3);
        check("div3_valid", 32'(valid3), 1);
        check("div1_react", 32'(react8), 10);
        go = 1'b0;
        green = 1'b0;
        tick();

        // Race sequence 7, foul, 4
        do_reset();
        race(7, 1'b0, 0, 7);
        race(0, 1'b1, 7, 7);
        race(4, 1'b0, 7, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
